ps2_rx: RTL

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx_if.sv | 21 ++
 rtl/ps2_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_if.sv
// Receive-side bus of the PS/2 receiver: FIFO read port plus the one-cycle
// status pulses. The receiver drives it through "master"; the consumer
// uses "slave".
interface ps2_rx_if;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overflow;
  logic       frame_err;
  logic       parity_err;

  modport master (
    input  rx_rd,
    output rx_data, rx_valid, overflow, frame_err, parity_err
  );

  modport slave (
    output rx_rd,
    input  rx_data, rx_valid, overflow, frame_err, parity_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver with a 4-entry byte FIFO.
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1); each bit is
// taken on a falling edge of the (already synchronous) PS/2 clock.
// Optional feature macro: PS2_RX_PARITY_CHK_EN -- when defined, frames with
// bad odd parity are rejected and reported on parity_err; when undefined the
// parity bit is ignored and parity_err is held at 0.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYC = 14000
) (
  input  logic     clk14,
  input  logic     rst,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.master rx
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [13:0] TO_LAST = 14'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        data_s1_q, data_s2_q;
  logic        clk_q;
  logic        fe;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [13:0] to_cnt_q, to_cnt_d;
  logic [13:0] to_inc;
  logic        timeout;
  logic        parity_ok;
  logic        push;
  logic        frame_err_d, frame_err_q;
  logic        overflow_d, overflow_q;

  logic [7:0]  mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        pop, full, push_ok;

`ifdef PS2_RX_PARITY_CHK_EN
  logic        par_q, par_d;
  logic        parity_err_d, parity_err_q;
`endif

  // Two-flop synchroniser for the raw data line and the edge-detect flop for
  // the PS/2 clock; both idle high so reset cannot fake a falling edge.
  always_ff @(posedge clk14) begin
    if (rst) begin
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      clk_q     <= 1'b1;
    end else begin
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
      clk_q     <= ps2_clk;
    end
  end

  assign fe = clk_q & ~ps2_clk;

  // Abort is taken on the edge where the idle-time counter steps to
  // TIMEOUT_CYC-1, i.e. TIMEOUT_CYC-1 clocks after the edge that saw the
  // last falling edge.
  assign to_inc  = to_cnt_q + 14'd1;
  assign timeout = (state_q != IDLE) && !fe && (to_inc == TO_LAST);

`ifdef PS2_RX_PARITY_CHK_EN
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Next-state logic: one bit consumed per falling edge, timeout aborts.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_RX_PARITY_CHK_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    to_cnt_d    = (state_q == IDLE || fe) ? 14'd0 : to_inc;
    if (timeout) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (fe) begin
      case (state_q)
        IDLE: begin
          // A high level on a falling edge is line noise, not a start bit.
          if (!data_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_CHK_EN
          par_d = data_s2_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_s2_q) begin
            frame_err_d = 1'b1;
          end else if (parity_ok) begin
            push = 1'b1;
          end else begin
`ifdef PS2_RX_PARITY_CHK_EN
            parity_err_d = 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk14) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      to_cnt_q    <= 14'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PS2_RX_PARITY_CHK_EN
  // Stored parity bit and its error pulse.
  always_ff @(posedge clk14) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign rx.parity_err = parity_err_q;
`else
  assign rx.parity_err = 1'b0;
`endif

  // A push into a full FIFO still succeeds when the head leaves in the same
  // cycle; the write slot then equals the old head slot, which is free.
  assign pop        = rx.rx_rd && (count_q != 3'd0);
  assign full       = (count_q == 3'd4);
  assign push_ok    = push && (!full || pop);
  assign overflow_d = push && full && !pop;

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk14) begin
    if (rst) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q    <= count_q + 3'(push_ok) - 3'(pop);
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk14) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx.rx_valid  = (count_q != 3'd0);
  assign rx.rx_data   = rx.rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign rx.overflow  = overflow_q;
  assign rx.frame_err = frame_err_q;

endmodule
